// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: ROM read port, redirect and issue handshake of the fetch front end
interface instr_fetch_queue_if;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        issue_ready;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        fetch_done;
  modport master (
    output rom_nrd, rom_addr, issue_valid, issue_instr, issue_pc, fetch_done,
    input  rom_data, redirect, redirect_pc, issue_ready
  );
  modport slave (
    input  rom_nrd, rom_addr, issue_valid, issue_instr, issue_pc, fetch_done,
    output rom_data, redirect, redirect_pc, issue_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: reads big-endian words from the instruction ROM into a small FIFO feeding issue
module instr_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          ROM_BYTES   = 100
) (
  input logic                 clk,
  input logic                 nrst,
  instr_fetch_queue_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  logic [31:0]   pc;
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [31:0]   q_pc [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          end_flag, fetch_en, pop;
  // 33-bit compare so a pc near 2^32 cannot wrap past the end check
  assign end_flag = ({1'b0, pc} + 33'd4) > 33'(ROM_BYTES);
  assign fetch_en = nrst & ~bus.redirect & ~end_flag & (count != (AW+1)'(QUEUE_DEPTH));
  assign pop = bus.issue_valid & bus.issue_ready;
  assign bus.rom_nrd = ~fetch_en;
  assign bus.rom_addr = pc;
  assign bus.issue_valid = count != '0;
  assign bus.issue_instr = q_instr[rd_ptr];
  assign bus.issue_pc = q_pc[rd_ptr];
  assign bus.fetch_done = end_flag & (count == '0);
  always_ff @(posedge clk) begin
    if (fetch_en) begin
      q_instr[wr_ptr] <= bus.rom_data;
      q_pc[wr_ptr] <= pc;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (bus.redirect) begin
      pc <= bus.redirect_pc & ~32'd3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (fetch_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, fetch_en} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scripted and random stimulus against a queue-based reference of the fetch front end
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int ROM_BYTES = 100;
  logic clk = 0;
  logic nrst = 1;
  int checks = 0;
  int errors = 0;
  int nfetch = 0;
  logic [7:0]  rom [ROM_BYTES];
  logic [31:0] mpc;
  logic [63:0] mq [$];
  logic [31:0] exp_stream [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
  instr_fetch_queue_if bus ();
  instr_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'd0), .ROM_BYTES(ROM_BYTES)) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input int a);
    return {rom[a], rom[a+1], rom[a+2], rom[a+3]};
  endfunction
  assign bus.rom_data = (!bus.rom_nrd && ({1'b0, bus.rom_addr} + 33'd4 <= 33'(ROM_BYTES)))
                        ? word_at(int'(bus.rom_addr)) : 'x;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one cycle: drive at negedge, compare against the model, advance the model by the coming edge
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic fe, pp;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    bus.issue_ready = rdy;
    #1;
    fe = !rd && (longint'(mpc) + 4 <= ROM_BYTES) && (mq.size() < DEPTH);
    pp = (mq.size() != 0) && rdy;
    check("rom_nrd", 32'(bus.rom_nrd), 32'(!fe));
    check("rom_addr", bus.rom_addr, mpc);
    check("issue_valid", 32'(bus.issue_valid), 32'(mq.size() != 0));
    check("fetch_done", 32'(bus.fetch_done), 32'((longint'(mpc) + 4 > ROM_BYTES) && mq.size() == 0));
    if (mq.size() != 0) begin
      check("issue_instr", bus.issue_instr, mq[0][63:32]);
      check("issue_pc", bus.issue_pc, mq[0][31:0]);
    end
    if (!bus.rom_nrd) nfetch++;
    if (rd) begin
      mq.delete();
      mpc = rpc & ~32'd3;
    end else begin
      if (pp) void'(mq.pop_front());
      if (fe) begin
        mq.push_back({word_at(int'(mpc)), mpc});
        mpc += 32'd4;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    logic rd;
    logic [31:0] rpc;
    for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'(i);
    bus.redirect = 0;
    bus.redirect_pc = 0;
    bus.issue_ready = 0;
    #1 nrst = 0;
    #1;
    check("rst_issue_valid", 32'(bus.issue_valid), 0);
    check("rst_rom_nrd", 32'(bus.rom_nrd), 1);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_fetch_done", 32'(bus.fetch_done), 0);
    mpc = 0;
    @(negedge clk);
    nrst = 1;
    cycle(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check("stream_instr", bus.issue_instr, exp_stream[i]);
      check("stream_pc", bus.issue_pc, 32'(4 * i));
      cycle(0, 0, 1);
    end
    cycle(1, 0, 1);
    nfetch = 0;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);
    check("bp_fetches", 32'(nfetch), 4);
    check("bp_rom_nrd", 32'(bus.rom_nrd), 1);
    check("bp_rom_addr", bus.rom_addr, 32'd16);
    check("bp_head", bus.issue_instr, 32'h00010203);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1);
    cycle(1, 32'h0000002B, 1);
    check("redir_empty", 32'(bus.issue_valid), 0);
    check("redir_addr", bus.rom_addr, 32'h28);
    cycle(0, 0, 1);
    check("redir_issue_pc", bus.issue_pc, 32'h28);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    cycle(1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    cycle(1, 0, 1);
    check("flush_pop_empty", 32'(bus.issue_valid), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    cycle(1, 32'd92, 1);
    nfetch = 0;
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    check("end_fetches", 32'(nfetch), 2);
    check("end_rom_addr", bus.rom_addr, 32'd100);
    check("end_rom_nrd", 32'(bus.rom_nrd), 1);
    check("end_done", 32'(bus.fetch_done), 1);
    cycle(1, 0, 1);
    check("end_done_clear", 32'(bus.fetch_done), 0);
    cycle(0, 0, 1);
    for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      rd = $urandom_range(0, 11) == 0;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 112));
      cycle(rd, rpc, 1'($urandom_range(0, 3) != 0));
    end
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    #3 nrst = 0;
    #1;
    check("arst_issue_valid", 32'(bus.issue_valid), 0);
    check("arst_rom_nrd", 32'(bus.rom_nrd), 1);
    check("arst_rom_addr", bus.rom_addr, 0);
    mq.delete();
    mpc = 0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1;
    for (int i = 0; i < 8; i++) cycle(0, 0, 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the Tomasulo core: the initiator on the instruction ROM read port. It drives the byte address and active-low read strobe, and captures the combinationally returned big-endian 32-bit word on the next clock edge. Captured words go into a small FIFO that feeds the issue stage with a valid/ready handshake. It supports a redirect (branch/jump) that flushes the queue, and it stops fetching at the end of ROM.

## Interface
- `QUEUE_DEPTH`, 4: instruction queue entries; power of two, at least 2.
- `RESET_PC`, 32'd0: byte address of the first fetch after reset.
- `ROM_BYTES`, 100: ROM size in bytes; a fetch is legal only when pc + 4 <= ROM_BYTES.
- `clk` input 1: single clock; all state updates on rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `rom_nrd` output 1: ROM read strobe, active-low.
- `rom_addr` output 32: ROM byte address, always equal to the current pc.
- `rom_data` input 32: ROM word; byte at addr goes in [31:24], addr+3 goes in [7:0]; valid the same cycle `rom_nrd`=0, high-Z otherwise.
- `redirect` input 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` input 32: new pc; bits [1:0] are ignored and forced to 0.
- `issue_ready` input 1: issue stage accepts the head entry this cycle.
- `issue_valid` output 1: queue non-empty.
- `issue_instr` output 32: head instruction word.
- `issue_pc` output 32: byte address the head word was fetched from.
- `fetch_done` output 1: end of ROM reached and queue empty.

## Operation
- State: `pc` (32), queue storage (instr, pc pairs), read pointer, write pointer, `count` (0..QUEUE_DEPTH), `end_flag`.
- `end_flag` = (pc + 4 > ROM_BYTES). Compare at 33-bit width so pc near 2^32 cannot wrap.
- fetch_en = nrst & ~redirect & ~end_flag & (count != QUEUE_DEPTH).
  - A full queue blocks fetch even when a pop happens in the same cycle. There is no bypass.
- `rom_nrd` = ~fetch_en (combinational). `rom_addr` = pc at all times.
- On an edge with fetch_en: push {rom_data, pc}, then pc <= pc + 4.
- pop = issue_valid & issue_ready. Pop advances the read pointer.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH.
- `issue_valid` = (count != 0). `issue_instr` and `issue_pc` come from the head entry.
  - Their value is don't-care when `issue_valid` is 0, but must be stable while `issue_valid`=1 and no pop has occurred.
- Redirect has highest priority. On the edge where `redirect`=1:
  - count <= 0 and both pointers <= 0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push. Any concurrent pop is absorbed by the flush.
  - Fetch resumes the following cycle, and `end_flag` is re-evaluated against the new pc.
- When `end_flag`=1: `rom_nrd` is held at 1 and pc holds. The queue keeps draining normally.
- `fetch_done` = end_flag & (count == 0).

## Timing
- Reset (nrst=0, asynchronous): pc=RESET_PC, count=0, pointers=0.
  - Outputs during reset: `issue_valid`=0, `rom_nrd`=1, `rom_addr`=RESET_PC, `fetch_done`=0 (or 1 if RESET_PC+4 > ROM_BYTES).
- Reset asserted mid-operation discards the queue contents immediately. No partial push may survive.
- Fetch-to-issue latency is 1 cycle: a word read in cycle N is on `issue_instr` with `issue_valid`=1 in cycle N+1.
- Throughput: one word per cycle while `issue_ready`=1 continuously (count settles at 1).
- With `issue_ready`=0: count reaches QUEUE_DEPTH after QUEUE_DEPTH fetch cycles, then `rom_nrd`=1.
- After `issue_ready` returns to 1: the pop frees a slot, and fetch restarts on the next cycle (one bubble).
- Redirect latency: the word at redirect_pc appears on issue 2 cycles after the redirect edge. That is one fetch cycle following the flush edge, then one capture cycle.

## Test plan
- Reset and stream: ROM bytes 0..15 = 00..0F, issue_ready=1. Required issue sequence:
  - 32'h00010203 @pc0, 32'h04050607 @pc4, 32'h08090A0B @pc8, 32'h0C0D0E0F @pc12.
  - First issue_valid on the 2nd cycle after nrst rises.
- Backpressure: issue_ready=0 for 8 cycles. Required: exactly 4 fetches (pc 0..12), then rom_nrd=1, pc=16, and issue_instr stable at 32'h00010203.
  - Then release issue_ready: words are delivered in order with no loss or duplication.
- Redirect: while streaming, assert redirect with redirect_pc=32'h0000002B. Required:
  - queue empties on the next cycle;
  - next fetch rom_addr=32'h28;
  - the 2nd cycle after the redirect edge shows issue_pc=32'h28, and no pre-redirect word follows it.
- Redirect with a concurrent pop at full queue: count=4, issue_ready=1, redirect=1 in the same cycle. Required: count=0 and no underflow or duplicate.
- End of ROM: ROM_BYTES=100, redirect_pc=92. Required:
  - fetches at 92 and 96 only, then rom_nrd stays 1 with rom_addr=100;
  - fetch_done=1 once both words are issued;
  - a later redirect to 0 clears fetch_done and resumes fetch.
- Asynchronous reset mid-stream: drop nrst between clock edges. Required: issue_valid=0 and rom_nrd=1 immediately, without waiting for an edge; pc=RESET_PC after release.
